// File: rtl/spi_flash_cmd_engine_pkg.sv
// Shared definitions for the SPI flash command engine: FSM encoding,
// flash opcodes and write-buffer geometry.
package spi_flash_cmd_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SHIFT,
    ST_WR_END,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_RD_END
  } state_t;

  // Flash opcodes used by the sequencers when they fill WBUF
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WREAR = 8'hC5;
  localparam logic [7:0] OP_READ  = 8'h03;

  // WBUF is 128 words of 32 bits; a 12-bit bit index covers all 4096 bits
  localparam int WBUF_WORDS = 128;
  localparam int WBUF_AW    = 7;
  localparam int WBIT_W     = 12;

endpackage

// File: rtl/spi_flash_cmd_engine_if.sv
// Sequencer-side request/response bundle of the command engine.
interface spi_flash_cmd_engine_if;
  logic        store_flash_command;
  logic [6:0]  wbuf_address;
  logic [31:0] flash_command;
  logic [11:0] flash_wr_nBits;
  logic        send_write_command;
  logic        end_write_command;
  logic        read_bitstream;
  logic        end_bitstream;
  logic        bitstream;
  logic        busy;

  modport master (
    output store_flash_command, wbuf_address, flash_command, flash_wr_nBits,
           send_write_command, read_bitstream,
    input  end_write_command, end_bitstream, bitstream, busy
  );

  modport slave (
    input  store_flash_command, wbuf_address, flash_command, flash_wr_nBits,
           send_write_command, read_bitstream,
    output end_write_command, end_bitstream, bitstream, busy
  );
endinterface

// File: rtl/spi_flash_cmd_engine_wbuf.sv
// 128x32 write buffer: word-wide synchronous write, single-bit read.
// Bit index i selects word i[11:5], bit 31-i[4:0], so words shift MSB first.
module spi_flash_cmd_engine_wbuf
  import spi_flash_cmd_engine_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [WBUF_AW-1:0] waddr,
  input  logic [31:0]        wdata,
  input  logic [WBIT_W-1:0]  bit_idx,
  output logic               rd_bit
);
  logic [31:0] mem [WBUF_WORDS];

  // word write port; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[bit_idx_unused_guard(waddr)] <= wdata;
  end

  assign rd_bit = mem[bit_idx[11:5]][~bit_idx[4:0]];

  function automatic logic [WBUF_AW-1:0] bit_idx_unused_guard(input logic [WBUF_AW-1:0] a);
    return a;
  endfunction
endmodule

// File: rtl/spi_flash_cmd_engine.sv
// SPI flash command engine: shifts WBUF contents out on MOSI for writes,
// sends WBUF word 0 as the READ command and streams MISO back for reads.
// MOSI changes on clk rise; the flash samples on SCK rise (= clk fall).
module spi_flash_cmd_engine
  import spi_flash_cmd_engine_pkg::*;
#(
  parameter logic [31:0] BITSTREAM_BITS = 32'd28_773_504,
  parameter int          CS_GAP         = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_flash_cmd_engine_if.slave host,
  output logic                 spi_cs_n,
  output logic                 spi_clk_en,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);
  localparam int               GAP_W      = $clog2(CS_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CS_GAP);

  state_t              state, state_nx;
  logic [WBIT_W-1:0]   idx;
  logic [WBIT_W-1:0]   nbits_q;
  logic [31:0]         rd_cnt;
  logic [GAP_W-1:0]    gap;
  logic                bitstream_q;
  logic                idle;
  logic                start_ok;
  logic                wbuf_bit;

  assign idle     = (state == ST_IDLE);
  // a store in the same cycle wins; the request launches one cycle later
  assign start_ok = idle && (gap == '0) && !host.store_flash_command;

  spi_flash_cmd_engine_wbuf u_wbuf (
    .clk     (clk),
    .we      (host.store_flash_command && idle),
    .waddr   (host.wbuf_address),
    .wdata   (host.flash_command),
    .bit_idx (idx),
    .rd_bit  (wbuf_bit)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // next-state: write request has priority over read
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) begin
          if (host.send_write_command)  state_nx = ST_WR_SHIFT;
          else if (host.read_bitstream) state_nx = ST_RD_CMD;
        end
      end
      ST_WR_SHIFT: if (idx == nbits_q)                    state_nx = ST_WR_END;
      ST_WR_END:   if (!host.send_write_command)          state_nx = ST_IDLE;
      ST_RD_CMD:   if (idx == WBIT_W'(31))                state_nx = ST_RD_DATA;
      ST_RD_DATA:  if (rd_cnt == BITSTREAM_BITS - 32'd1)  state_nx = ST_RD_END;
      ST_RD_END:   if (!host.read_bitstream)              state_nx = ST_IDLE;
      default:                                            state_nx = ST_IDLE;
    endcase
  end

  // pin decode; MOSI reads WBUF at the current bit index
  always_comb begin
    spi_cs_n   = 1'b1;
    spi_clk_en = 1'b0;
    spi_mosi   = 1'b0;
    case (state)
      ST_WR_SHIFT, ST_RD_CMD: begin
        spi_cs_n   = 1'b0;
        spi_clk_en = 1'b1;
        spi_mosi   = wbuf_bit;
      end
      ST_RD_DATA: begin
        spi_cs_n   = 1'b0;
        spi_clk_en = 1'b1;
      end
      default: ;
    endcase
  end

  // counters, latched write length, CS gap timer and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      nbits_q     <= '0;
      rd_cnt      <= '0;
      gap         <= GAP_RELOAD;
      bitstream_q <= 1'b1;
    end else begin
      bitstream_q <= (state == ST_RD_DATA) ? spi_miso : 1'b1;
      case (state)
        ST_IDLE: begin
          idx    <= '0;
          rd_cnt <= '0;
          if (gap != '0) gap <= gap - 1'b1;
          if (start_ok && host.send_write_command) nbits_q <= host.flash_wr_nBits;
        end
        ST_WR_SHIFT, ST_RD_CMD: idx <= idx + 1'b1;
        ST_RD_DATA:             rd_cnt <= rd_cnt + 32'd1;
        ST_WR_END: if (!host.send_write_command) gap <= GAP_RELOAD;
        ST_RD_END: if (!host.read_bitstream)     gap <= GAP_RELOAD;
        default: ;
      endcase
    end
  end

  assign host.end_write_command = (state == ST_WR_END);
  assign host.end_bitstream     = (state == ST_RD_END);
  assign host.bitstream         = bitstream_q;
  assign host.busy              = !idle;

endmodule

// File: tb/tb_spi_flash_cmd_engine.sv
// Self-checking bench for spi_flash_cmd_engine. A word-array model of WBUF
// gives the expected MOSI bits; random MISO data gives the expected stream.
module tb_spi_flash_cmd_engine;
  localparam int NB  = 64;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_cs_n, spi_clk_en, spi_mosi;
  logic spi_miso = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [128];
  logic [31:0] cap;

  spi_flash_cmd_engine_if host();

  spi_flash_cmd_engine #(.BITSTREAM_BITS(32'd64), .CS_GAP(GAP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .host       (host),
    .spi_cs_n   (spi_cs_n),
    .spi_clk_en (spi_clk_en),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  // expected write bit i: word i/32, MSB first
  function automatic logic mbit(input int i);
    logic [31:0] w;
    w = mem_model[i / 32];
    return w[31 - (i % 32)];
  endfunction

  task automatic store_word(input int addr, input logic [31:0] data, input bit upd);
    @(posedge clk); #1;
    host.store_flash_command = 1'b1;
    host.wbuf_address        = 7'(addr);
    host.flash_command       = data;
    @(posedge clk); #1;
    host.store_flash_command = 1'b0;
    if (upd) mem_model[addr] = data;
  endtask

  task automatic write_txn(input int nb, input int hold, output int wait_n);
    int cnt, bad, first_bad;
    logic exp_b;
    host.flash_wr_nBits     = 12'(nb);
    host.send_write_command = 1'b1;
    wait_n = 0;
    while (spi_cs_n !== 1'b0 && wait_n < 300) begin @(negedge clk); wait_n++; end
    checks++;
    if (spi_cs_n !== 1'b0) begin
      errors++; $display("FAIL wr_start: cs_n=%b, required 0", spi_cs_n);
    end
    cnt = 0; bad = 0; first_bad = -1; cap = '0;
    while (spi_cs_n === 1'b0 && cnt < 5000) begin
      exp_b = (cnt < 4096) ? mbit(cnt) : 1'b0;
      if (spi_mosi !== exp_b || spi_clk_en !== 1'b1 || host.end_write_command !== 1'b0) begin
        if (bad == 0) first_bad = cnt;
        bad++;
      end
      if (cnt < 32) cap = {cap[30:0], spi_mosi};
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != nb + 1) begin
      errors++; $display("FAIL wr_len: cs_n low %0d cycles, required %0d", cnt, nb + 1);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wr_mosi: %0d bad bits, first at %0d, required 0", bad, first_bad);
    end
    checks++;
    if (host.end_write_command !== 1'b1 || spi_clk_en !== 1'b0 || host.busy !== 1'b1) begin
      errors++; $display("FAIL wr_end: end=%b clk_en=%b busy=%b, required 1 0 1",
                         host.end_write_command, spi_clk_en, host.busy);
    end
    repeat (hold) @(negedge clk);
    checks++;
    if (host.end_write_command !== 1'b1 || spi_cs_n !== 1'b1) begin
      errors++; $display("FAIL wr_hold: end=%b cs_n=%b, required 1 1", host.end_write_command, spi_cs_n);
    end
    @(posedge clk); #1;
    host.send_write_command = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (host.end_write_command !== 1'b0 || host.busy !== 1'b0 || spi_cs_n !== 1'b1) begin
      errors++; $display("FAIL wr_idle: end=%b busy=%b cs_n=%b, required 0 0 1",
                         host.end_write_command, host.busy, spi_cs_n);
    end
  endtask

  task automatic read_txn(input logic [NB-1:0] d, input int drop_at, output int wait_n);
    int c, bad, first_bad;
    host.read_bitstream = 1'b1;
    wait_n = 0;
    while (spi_cs_n !== 1'b0 && wait_n < 300) begin @(negedge clk); wait_n++; end
    checks++;
    if (spi_cs_n !== 1'b0) begin
      errors++; $display("FAIL rd_start: cs_n=%b, required 0", spi_cs_n);
    end
    c = 0; bad = 0; first_bad = -1; cap = '0;
    while (spi_cs_n === 1'b0 && c < 300) begin
      if (c < 32) cap = {cap[30:0], spi_mosi};
      else begin
        if (spi_mosi !== 1'b0) begin if (bad == 0) first_bad = c; bad++; end
        if (c - 32 < NB) spi_miso = d[c - 32];
      end
      if (c <= 32 && host.bitstream !== 1'b1) begin if (bad == 0) first_bad = c; bad++; end
      if (c >= 33 && c - 33 < NB && host.bitstream !== d[c - 33]) begin
        if (bad == 0) first_bad = c; bad++;
      end
      if (spi_clk_en !== 1'b1 || host.end_bitstream !== 1'b0) begin if (bad == 0) first_bad = c; bad++; end
      if (c == drop_at) host.read_bitstream = 1'b0;
      c++;
      @(negedge clk);
    end
    checks++;
    if (c != 32 + NB) begin
      errors++; $display("FAIL rd_len: cs_n low %0d cycles, required %0d", c, 32 + NB);
    end
    checks++;
    if (cap !== mem_model[0]) begin
      errors++; $display("FAIL rd_cmd: got %h, required %h", cap, mem_model[0]);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rd_data: %0d bad cycles, first at %0d, required 0", bad, first_bad);
    end
    checks++;
    if (host.end_bitstream !== 1'b1 || host.bitstream !== d[NB-1] || spi_clk_en !== 1'b0) begin
      errors++; $display("FAIL rd_end: end=%b bit=%b clk_en=%b, required 1 %b 0",
                         host.end_bitstream, host.bitstream, spi_clk_en, d[NB-1]);
    end
    if (drop_at < 0) begin
      @(negedge clk);
      checks++;
      if (host.end_bitstream !== 1'b1 || host.bitstream !== 1'b1) begin
        errors++; $display("FAIL rd_hold: end=%b bit=%b, required 1 1", host.end_bitstream, host.bitstream);
      end
      @(posedge clk); #1;
      host.read_bitstream = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (host.end_bitstream !== 1'b0 || host.busy !== 1'b0 || host.bitstream !== 1'b1 || spi_cs_n !== 1'b1) begin
      errors++; $display("FAIL rd_idle: end=%b busy=%b bit=%b cs_n=%b, required 0 0 1 1",
                         host.end_bitstream, host.busy, host.bitstream, spi_cs_n);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (spi_cs_n !== 1'b1 || spi_clk_en !== 1'b0 || spi_mosi !== 1'b0 || host.bitstream !== 1'b1 ||
        host.end_write_command !== 1'b0 || host.end_bitstream !== 1'b0 || host.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: cs_n=%b clk_en=%b mosi=%b bit=%b endw=%b endr=%b busy=%b, required 1 0 0 1 0 0 0",
               name, spi_cs_n, spi_clk_en, spi_mosi, host.bitstream,
               host.end_write_command, host.end_bitstream, host.busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_write8();
    int w;
    store_word(0, 32'h0600_0000, 1'b1);
    write_txn(7, 3, w);
    checks++;
    if (cap[7:0] !== 8'h06) begin
      errors++; $display("FAIL write8_byte: got %h, required 06", cap[7:0]);
    end
    // back-to-back: chip select must stay high at least CS_GAP cycles
    write_txn(7, 0, w);
    checks++;
    if (w < GAP) begin
      errors++; $display("FAIL cs_gap: idle %0d cycles, required >= %0d", w, GAP);
    end
  endtask

  task automatic test_write16();
    int w;
    store_word(0, 32'hC501_0000, 1'b1);
    write_txn(15, 1, w);
    checks++;
    if (cap[15:0] !== 16'hC501) begin
      errors++; $display("FAIL write16_a: got %h, required c501", cap[15:0]);
    end
    store_word(0, 32'hC500_0000, 1'b1);
    write_txn(15, 2, w);
    checks++;
    if (cap[15:0] !== 16'hC500) begin
      errors++; $display("FAIL write16_b: got %h, required c500", cap[15:0]);
    end
  endtask

  task automatic test_write_random();
    int w;
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 4; a++) store_word(a, $urandom(), 1'b1);
      write_txn($urandom_range(1, 127), $urandom_range(0, 3), w);
    end
  endtask

  task automatic test_read_a5();
    int w;
    logic [NB-1:0] d;
    logic [7:0] a5;
    a5 = 8'hA5;
    for (int j = 0; j < NB; j++) d[j] = a5[7 - (j % 8)];
    store_word(0, {8'h03, 24'h00_0000}, 1'b1);
    read_txn(d, -1, w);
  endtask

  task automatic test_read_random();
    int w;
    logic [NB-1:0] d;
    d = {$urandom(), $urandom()};
    store_word(0, {8'h03, 24'($urandom())}, 1'b1);
    read_txn(d, -1, w);
  endtask

  task automatic test_early_drop();
    int w;
    logic [NB-1:0] d;
    d = {$urandom(), $urandom()};
    read_txn(d, 5, w);
  endtask

  task automatic test_long_write();
    int w, n;
    for (int i = 0; i < 128; i++) store_word(i, {8'(i), 24'($urandom())}, 1'b1);
    fork
      write_txn(4095, 1, w);
      begin
        n = 0;
        while (spi_cs_n !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        repeat ($urandom_range(50, 300)) @(negedge clk);
        store_word(127, ~mem_model[127], 1'b0);
      end
    join
  endtask

  task automatic test_simultaneous();
    int w;
    logic [NB-1:0] d;
    d = {$urandom(), $urandom()};
    store_word(0, {8'h03, 24'($urandom())}, 1'b1);
    host.read_bitstream = 1'b1;
    write_txn($urandom_range(8, 40), 2, w);
    read_txn(d, -1, w);
    checks++;
    if (w < GAP) begin
      errors++; $display("FAIL sim_gap: idle %0d cycles before read, required >= %0d", w, GAP);
    end
  endtask

  task automatic test_reset_mid();
    int n, w;
    logic [NB-1:0] d;
    host.read_bitstream = 1'b1;
    n = 0;
    while (spi_cs_n !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_async");
    host.read_bitstream = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    d = {$urandom(), $urandom()};
    read_txn(d, -1, w);
  endtask

  initial begin
    host.store_flash_command = 1'b0;
    host.wbuf_address        = '0;
    host.flash_command       = '0;
    host.flash_wr_nBits      = '0;
    host.send_write_command  = 1'b0;
    host.read_bitstream      = 1'b0;
    test_reset();
    test_write8();
    test_write16();
    test_write_random();
    test_read_a5();
    test_read_random();
    test_early_drop();
    test_long_write();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
